photonic_channel_arbiter: RTL

- Round-robin arbiter that shares the single photonic data channel between the nodes of one cluster.
- Picks one requesting node and broadcasts a control grant packet {node_id, word_count}. It then tracks the granted node's data burst beat by beat.
- After the burst it inserts a laser-retune guard interval before the next grant.
- Sits beside the node `computer` instances. Its control packet uses the same 32-bit format as `control_rx_packet`: upper 16 bits are the node id, lower 16 bits are the word count.

---
 rtl/photonic_channel_arbiter_if.sv | 25 ++
 rtl/photonic_channel_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/photonic_channel_arbiter_if.sv
// Bundle between the photonic channel arbiter and the cluster nodes.
// The arbiter takes the slave side; the nodes (or a bench) drive the master side.
interface photonic_channel_arbiter_if #(
    parameter int N_NODES = 4
);
    logic [15:0]           max_node;
    logic [N_NODES-1:0]    req;
    logic [N_NODES*16-1:0] req_len;
    logic                  data_valid;
    logic [N_NODES-1:0]    grant;
    logic [31:0]           control_tx_packet;
    logic [15:0]           data_rx_node_id;
    logic                  busy;
    logic                  abort;

    modport master (
        output max_node, req, req_len, data_valid,
        input  grant, control_tx_packet, data_rx_node_id, busy, abort
    );

    modport slave (
        input  max_node, req, req_len, data_valid,
        output grant, control_tx_packet, data_rx_node_id, busy, abort
    );
endinterface

// File: rtl/photonic_channel_arbiter.sv
// Round-robin owner of the shared photonic data channel.
// Grants one node, tracks its burst with a watchdog, then inserts a retune guard.
module photonic_channel_arbiter #(
    parameter int N_NODES      = 4,
    parameter int MAX_BURST    = 16,
    parameter int GUARD_CYCLES = 2,
    parameter int TIMEOUT      = 8
) (
    input  logic clk,
    input  logic rst,
    photonic_channel_arbiter_if.slave bus
);
    localparam int PW = (N_NODES > 1) ? $clog2(N_NODES) : 1;
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam bit HAS_GUARD = (GUARD_CYCLES > 0);
    localparam logic [GW-1:0] GUARD_LAST =
        GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_FULL = TW'(TIMEOUT);
    localparam logic [15:0] N16   = 16'(N_NODES);
    localparam logic [15:0] MAX16 = 16'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BURST,
        GUARD
    } state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] win_q;
    logic [15:0]   len_q;
    logic [15:0]   remaining;
    logic [TW-1:0] idle_cnt;
    logic [GW-1:0] guard_cnt;

    logic [15:0]   active;
    logic [15:0]   ptr_eff;
    logic          any_req;
    logic [PW-1:0] win;
    logic [15:0]   win_len;
    logic [PW-1:0] next_ptr;
    logic          last_beat;
    logic          watchdog;
    logic          grant_empty;
    logic          guard_done;
    logic          burst_over;
    logic          to_guard;
    logic          arb_point;

    // Active window and wrapping round-robin search from the pointer.
    always_comb begin
        logic [15:0] idx;
        logic [15:0] wn;
        logic [15:0] raw;
        active  = (bus.max_node > N16) ? N16 : bus.max_node;
        ptr_eff = (16'(rr_ptr) >= active) ? 16'd0 : 16'(rr_ptr);
        any_req = 1'b0;
        win     = '0;
        for (int k = 0; k < N_NODES; k++) begin
            idx = ptr_eff + 16'(k);
            if (idx >= active) idx = idx - active;
            if (!any_req && (16'(k) < active) && bus.req[idx[PW-1:0]]) begin
                any_req = 1'b1;
                win     = idx[PW-1:0];
            end
        end
        raw      = bus.req_len[{win, 4'b0000} +: 16];
        win_len  = (raw > MAX16) ? MAX16 : raw;
        wn       = 16'(win) + 16'd1;
        next_ptr = (wn >= active) ? '0 : PW'(wn);
    end

    // Exit conditions; arbitration also runs on the edge that would enter IDLE.
    always_comb begin
        last_beat   = (state == BURST) && bus.data_valid && (remaining == 16'd1);
        watchdog    = (state == BURST) && !bus.data_valid && (idle_cnt == TO_LAST);
        grant_empty = (state == GRANT) && (len_q == 16'd0);
        guard_done  = (state == GUARD) && (guard_cnt == GUARD_LAST);
        burst_over  = last_beat || watchdog || grant_empty;
        to_guard    = HAS_GUARD && burst_over;
        arb_point   = (state == IDLE) || guard_done || (!HAS_GUARD && burst_over);
    end

    // Channel FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            rr_ptr                <= '0;
            win_q                 <= '0;
            len_q                 <= '0;
            remaining             <= '0;
            idle_cnt              <= '0;
            guard_cnt             <= '0;
            bus.grant             <= '0;
            bus.control_tx_packet <= '0;
            bus.data_rx_node_id   <= '0;
            bus.busy              <= 1'b0;
            bus.abort             <= 1'b0;
        end else begin
            bus.control_tx_packet <= '0;
            bus.abort             <= 1'b0;
            unique case (state)
                IDLE: ;
                GRANT: begin
                    if (len_q != 16'd0) begin
                        remaining           <= len_q;
                        idle_cnt            <= '0;
                        bus.data_rx_node_id <= 16'(win_q) + 16'd1;
                        state               <= BURST;
                    end
                end
                BURST: begin
                    if (bus.data_valid) begin
                        remaining <= remaining - 16'd1;
                        idle_cnt  <= '0;
                    end else if (idle_cnt != TO_FULL) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                    if (watchdog) bus.abort <= 1'b1;
                end
                GUARD: guard_cnt <= guard_cnt + 1'b1;
            endcase
            if (to_guard) begin
                state               <= GUARD;
                guard_cnt           <= '0;
                bus.grant           <= '0;
                bus.data_rx_node_id <= '0;
            end
            if (arb_point) begin
                state               <= IDLE;
                bus.grant           <= '0;
                bus.data_rx_node_id <= '0;
                bus.busy            <= 1'b0;
                if (any_req) begin
                    state                 <= GRANT;
                    win_q                 <= win;
                    len_q                 <= win_len;
                    rr_ptr                <= next_ptr;
                    bus.grant             <= N_NODES'(1) << win;
                    bus.busy              <= 1'b1;
                    bus.control_tx_packet <= {16'(win) + 16'd1, win_len};
                end
            end
        end
    end
endmodule
